// File: rtl/b_pkg.sv
// Shared types and widths for the writeback slice.
package b_pkg;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 5;

   // Load width and extension selector carried down from the decoder.
   typedef enum logic [2:0] {
      LT_LW  = 3'd0,
      LT_LH  = 3'd1,
      LT_LHU = 3'd2,
      LT_LB  = 3'd3,
      LT_LBU = 3'd4
   } load_type_e;

endpackage

// File: rtl/b_wb_fifo.sv
// Pending-write queue for out-of-order MDU results. Each entry has a valid
// bit so that a newer in-order write to the same register can cancel it.
// Cancelled (or address-0) entries are dropped from the head on their own,
// without ever occupying the register-file write port.
module b_wb_fifo #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int DEPTH  = 2
) (
   input  logic              clk,
   input  logic              srst,
   input  logic              push,
   input  logic [ADDR_W-1:0] push_addr,
   input  logic [DATA_W-1:0] push_data,
   input  logic              pop,
   input  logic              squash,
   input  logic [ADDR_W-1:0] squash_addr,
   output logic              head_valid,
   output logic [ADDR_W-1:0] head_addr,
   output logic [DATA_W-1:0] head_data,
   output logic              ready,
   output logic              any_valid
);
   import b_pkg::*;

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PTR_W-1:0] PTR_ONE = 1;
   localparam logic [PTR_W:0]   CNT_ONE = 1;
   localparam logic [PTR_W:0]   CNT_MAX = (PTR_W+1)'(DEPTH);

   logic [ADDR_W-1:0] addr_mem [DEPTH];
   logic [DATA_W-1:0] data_mem [DEPTH];
   logic [DEPTH-1:0]  valid_reg, valid_next;
   logic [DEPTH-1:0]  squash_hit;
   logic [PTR_W-1:0]  rd_ptr_reg, wr_ptr_reg;
   logic [PTR_W:0]    count_reg;
   logic              not_empty, do_push, do_pop;

   assign not_empty  = (count_reg != '0);
   assign ready      = (count_reg != CNT_MAX);
   assign do_push    = push && ready;
   // A valid head leaves only when the port is free; a dead head always leaves.
   assign do_pop     = not_empty && (pop || !valid_reg[rd_ptr_reg]);
   assign head_valid = not_empty && valid_reg[rd_ptr_reg];
   assign head_addr  = addr_mem[rd_ptr_reg];
   assign head_data  = data_mem[rd_ptr_reg];
   assign any_valid  = |valid_reg;

   // Per-entry address match against the in-order write retiring this cycle.
   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_squash
         assign squash_hit[gi] = squash && (addr_mem[gi] == squash_addr);
      end
   endgenerate

   // Next valid bits: squash older entries first, then pop, then the new push
   // (so a same-cycle push to the squashed address survives).
   always_comb begin
      valid_next = valid_reg & ~squash_hit;
      if (do_pop) begin
         valid_next[rd_ptr_reg] = 1'b0;
      end
      if (do_push) begin
         valid_next[wr_ptr_reg] = (push_addr != '0);
      end
   end

   // Pointers, occupancy and valid bits.
   always_ff @(posedge clk) begin
      if (srst) begin
         valid_reg  <= '0;
         rd_ptr_reg <= '0;
         wr_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         valid_reg <= valid_next;
         if (do_pop) begin
            rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
         end
         if (do_push) begin
            wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
         end
         case ({do_push, do_pop})
            2'b10:   count_reg <= count_reg + CNT_ONE;
            2'b01:   count_reg <= count_reg - CNT_ONE;
            default: count_reg <= count_reg;
         endcase
      end
   end

   // Entry payload storage; contents are meaningless unless the valid bit is set.
   always_ff @(posedge clk) begin
      if (do_push) begin
         addr_mem[wr_ptr_reg] <= push_addr;
         data_mem[wr_ptr_reg] <= push_data;
      end
   end

endmodule

// File: rtl/b_wb_stage.sv
// MIPS writeback stage: MEM/WB register with load extraction, plus the
// arbiter for the single register-file write port between in-order results
// and queued MDU results.
module b_wb_stage #(
   parameter int DATA_W     = b_pkg::DATA_W,
   parameter int ADDR_W     = b_pkg::ADDR_W,
   parameter int FIFO_DEPTH = 2
) (
   input  logic              i_sys_clock,
   input  logic              i_sys_reset,
   input  logic              i_wb_stall,
   input  logic              i_wb_flush,
   input  logic              i_mem_valid,
   input  logic              i_mem_regwr,
   input  logic              i_mem_memtoreg,
   input  logic [ADDR_W-1:0] i_mem_wr_addr,
   input  logic [DATA_W-1:0] i_mem_alu_result,
   input  logic [DATA_W-1:0] i_mem_load_data,
   input  logic [2:0]        i_mem_load_type,
   input  logic              i_mdu_valid,
   input  logic [ADDR_W-1:0] i_mdu_wr_addr,
   input  logic [DATA_W-1:0] i_mdu_wr_data,
   output logic              o_mdu_ready,
   output logic              o_wb_regwr,
   output logic [ADDR_W-1:0] o_wb_wr_addr,
   output logic [DATA_W-1:0] o_wb_wr_data,
   output logic              o_wb_pending
);
   import b_pkg::*;

   logic              wb_valid_reg, wb_regwr_reg;
   logic [ADDR_W-1:0] wb_addr_reg;
   logic [DATA_W-1:0] wb_data_reg;
   logic [7:0]        load_byte;
   logic [15:0]       load_half;
   logic [DATA_W-1:0] load_ext, mem_wr_data;
   logic              pipe_active, fifo_ready, fifo_any_valid, head_valid;
   logic [ADDR_W-1:0] head_addr;
   logic [DATA_W-1:0] head_data;

   // Pick the addressed byte/half of the aligned word and extend it.
   always_comb begin
      load_byte = i_mem_load_data[{i_mem_alu_result[1:0], 3'b000} +: 8];
      load_half = i_mem_alu_result[1] ? i_mem_load_data[31:16] : i_mem_load_data[15:0];
      case (load_type_e'(i_mem_load_type))
         LT_LH:   load_ext = {{(DATA_W-16){load_half[15]}}, load_half};
         LT_LHU:  load_ext = {{(DATA_W-16){1'b0}}, load_half};
         LT_LB:   load_ext = {{(DATA_W-8){load_byte[7]}}, load_byte};
         LT_LBU:  load_ext = {{(DATA_W-8){1'b0}}, load_byte};
         default: load_ext = i_mem_load_data;
      endcase
      mem_wr_data = i_mem_memtoreg ? load_ext : i_mem_alu_result;
   end

   // MEM/WB register: flush beats stall, stall holds, otherwise capture.
   always_ff @(posedge i_sys_clock) begin
      if (i_sys_reset) begin
         wb_valid_reg <= 1'b0;
         wb_regwr_reg <= 1'b0;
         wb_addr_reg  <= '0;
         wb_data_reg  <= '0;
      end else if (i_wb_flush) begin
         wb_valid_reg <= 1'b0;
      end else if (!i_wb_stall) begin
         wb_valid_reg <= i_mem_valid;
         wb_regwr_reg <= i_mem_regwr;
         wb_addr_reg  <= i_mem_wr_addr;
         wb_data_reg  <= mem_wr_data;
      end
   end

   assign pipe_active  = wb_valid_reg && wb_regwr_reg && (wb_addr_reg != '0);
   assign o_mdu_ready  = !i_sys_reset && fifo_ready;
   assign o_wb_pending = fifo_any_valid;

   b_wb_fifo #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .DEPTH  (FIFO_DEPTH)
   ) u_fifo (
      .clk         (i_sys_clock),
      .srst        (i_sys_reset),
      .push        (i_mdu_valid && o_mdu_ready),
      .push_addr   (i_mdu_wr_addr),
      .push_data   (i_mdu_wr_data),
      .pop         (!pipe_active),
      .squash      (pipe_active),
      .squash_addr (wb_addr_reg),
      .head_valid  (head_valid),
      .head_addr   (head_addr),
      .head_data   (head_data),
      .ready       (fifo_ready),
      .any_valid   (fifo_any_valid)
   );

   // Write-port arbitration: in-order result first, queued MDU result otherwise.
   always_comb begin
      o_wb_regwr   = 1'b0;
      o_wb_wr_addr = '0;
      o_wb_wr_data = '0;
      if (pipe_active) begin
         o_wb_regwr   = 1'b1;
         o_wb_wr_addr = wb_addr_reg;
         o_wb_wr_data = wb_data_reg;
      end else if (head_valid) begin
         o_wb_regwr   = 1'b1;
         o_wb_wr_addr = head_addr;
         o_wb_wr_data = head_data;
      end
   end

endmodule

// File: tb/tb_b_wb_stage.sv
// Directed bench for b_wb_stage: expected register-file writes are queued as
// stimulus is driven and matched against every cycle the write port is active.
module tb_b_wb_stage;
   import b_pkg::*;

   typedef struct packed {
      logic [4:0]  addr;
      logic [31:0] data;
   } wr_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall, flush;
   logic        mem_valid, mem_regwr, mem_memtoreg;
   logic [4:0]  mem_addr;
   logic [31:0] mem_alu, mem_ld;
   logic [2:0]  mem_lt;
   logic        mdu_valid;
   logic [4:0]  mdu_addr;
   logic [31:0] mdu_data;
   logic        mdu_ready, wb_regwr, wb_pending;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data;

   wr_t exp_q[$];
   int  n_assert = 0;
   int  n_fail   = 0;

   b_wb_stage #(.DATA_W(32), .ADDR_W(5), .FIFO_DEPTH(2)) dut (
      .i_sys_clock      (clk),
      .i_sys_reset      (rst),
      .i_wb_stall       (stall),
      .i_wb_flush       (flush),
      .i_mem_valid      (mem_valid),
      .i_mem_regwr      (mem_regwr),
      .i_mem_memtoreg   (mem_memtoreg),
      .i_mem_wr_addr    (mem_addr),
      .i_mem_alu_result (mem_alu),
      .i_mem_load_data  (mem_ld),
      .i_mem_load_type  (mem_lt),
      .i_mdu_valid      (mdu_valid),
      .i_mdu_wr_addr    (mdu_addr),
      .i_mdu_wr_data    (mdu_data),
      .o_mdu_ready      (mdu_ready),
      .o_wb_regwr       (wb_regwr),
      .o_wb_wr_addr     (wb_addr),
      .o_wb_wr_data     (wb_data),
      .o_wb_pending     (wb_pending)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, observed=running required=done");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic expect_wr(input logic [4:0] a, input logic [31:0] d);
      wr_t e;
      e.addr = a;
      e.data = d;
      exp_q.push_back(e);
   endtask

   // Every active write-port cycle must match the oldest expected write.
   task automatic port_check();
      wr_t e;
      if (wb_regwr === 1'b1) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_write", wb_regwr, 1'b0);
         end else begin
            e = exp_q.pop_front();
            chk("wr_addr", wb_addr, e.addr);
            chk("wr_data", wb_data, e.data);
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      port_check();
   endtask

   task automatic pipe(input logic [4:0] a, input logic [31:0] d, input bit exp_it);
      mem_valid = 1'b1; mem_regwr = 1'b1; mem_memtoreg = 1'b0;
      mem_addr = a; mem_alu = d; mem_ld = '0; mem_lt = LT_LW;
      if (exp_it && a != 0) expect_wr(a, d);
   endtask

   task automatic load(input logic [4:0] a, input logic [31:0] alu, input logic [31:0] ld,
                       input load_type_e lt, input logic [31:0] expd);
      mem_valid = 1'b1; mem_regwr = 1'b1; mem_memtoreg = 1'b1;
      mem_addr = a; mem_alu = alu; mem_ld = ld; mem_lt = lt;
      expect_wr(a, expd);
   endtask

   task automatic bubble();
      mem_valid = 1'b0; mem_regwr = 1'b0;
   endtask

   task automatic mdu(input logic v, input logic [4:0] a, input logic [31:0] d);
      mdu_valid = v; mdu_addr = a; mdu_data = d;
   endtask

   task automatic idle_check(input string tag);
      chk({tag, "_regwr"}, wb_regwr, 1'b0);
      chk({tag, "_addr"}, wb_addr, 5'd0);
      chk({tag, "_data"}, wb_data, 32'd0);
      chk({tag, "_pending"}, wb_pending, 1'b0);
   endtask

   initial begin
      rst = 1'b1; stall = 1'b0; flush = 1'b0;
      bubble(); mem_memtoreg = 1'b0; mem_addr = '0; mem_alu = '0; mem_ld = '0; mem_lt = LT_LW;
      mdu(1'b0, 5'd0, 32'd0);

      // Reset
      tick();
      tick();
      idle_check("reset");
      chk("reset_ready", mdu_ready, 1'b0);
      rst = 1'b0;
      #1;
      chk("ready_after_reset", mdu_ready, 1'b1);

      // Loads and ALU result, back to back
      load(5'd8,  32'h0000_1000, 32'h8899_AABB, LT_LW,  32'h8899_AABB); tick();
      load(5'd10, 32'h0000_1003, 32'h8011_2233, LT_LB,  32'hFFFF_FF80); tick();
      load(5'd11, 32'h0000_1003, 32'h8011_2233, LT_LBU, 32'h0000_0080); tick();
      load(5'd12, 32'h0000_1002, 32'h8011_2233, LT_LH,  32'hFFFF_8011); tick();
      load(5'd13, 32'h0000_1002, 32'h8011_2233, LT_LHU, 32'h0000_8011); tick();
      load(5'd14, 32'h0000_1000, 32'h8011_2233, LT_LH,  32'h0000_2233); tick();
      load(5'd15, 32'h0000_1001, 32'h8011_2233, LT_LB,  32'h0000_0022); tick();
      load(5'd16, 32'h0000_1000, 32'h8011_2233, LT_LBU, 32'h0000_0033); tick();
      pipe(5'd17, 32'hDEAD_BEEF, 1'b1); tick();

      // MDU result waits behind in-order writes, drains on the first bubble
      pipe(5'd9, 32'h99, 1'b1); mdu(1'b1, 5'd5, 32'h1234); tick();
      mdu(1'b0, 5'd0, 32'd0);
      chk("mdu_pending_1", wb_pending, 1'b1);
      pipe(5'd9, 32'h9A, 1'b1); tick();
      chk("mdu_pending_2", wb_pending, 1'b1);
      bubble(); expect_wr(5'd5, 32'h1234); tick();
      chk("mdu_drain_pending", wb_pending, 1'b1);
      tick();
      idle_check("mdu_drained");

      // Full FIFO back-pressure
      pipe(5'd9, 32'h100, 1'b1); mdu(1'b1, 5'd20, 32'hA); tick();
      chk("full_ready_1", mdu_ready, 1'b1);
      pipe(5'd9, 32'h101, 1'b1); mdu(1'b1, 5'd21, 32'hB); tick();
      chk("full_ready_2", mdu_ready, 1'b0);
      pipe(5'd9, 32'h102, 1'b1); mdu(1'b1, 5'd22, 32'hC); tick();
      chk("full_held", mdu_ready, 1'b0);
      bubble(); expect_wr(5'd20, 32'hA); tick();
      chk("full_draining", mdu_ready, 1'b0);
      pipe(5'd9, 32'h103, 1'b1); tick();
      chk("full_ready_after_drain", mdu_ready, 1'b1);
      pipe(5'd9, 32'h104, 1'b1); tick();
      mdu(1'b0, 5'd0, 32'd0);
      chk("full_held_accepted", mdu_ready, 1'b0);
      bubble(); expect_wr(5'd21, 32'hB); tick();
      expect_wr(5'd22, 32'hC); tick();
      tick();
      idle_check("full_drained");

      // WAW squash: queued reg 7 is overwritten by the pipeline
      pipe(5'd9, 32'h200, 1'b1); mdu(1'b1, 5'd7, 32'hAAAA); tick();
      mdu(1'b0, 5'd0, 32'd0);
      pipe(5'd7, 32'hBBBB, 1'b1); tick();
      chk("waw_pending_before", wb_pending, 1'b1);
      bubble(); tick();
      idle_check("waw_squashed");
      tick();
      idle_check("waw_idle");

      // Same-cycle push to the retiring address is newer and survives
      pipe(5'd7, 32'hCCCC, 1'b1); tick();
      bubble(); mdu(1'b1, 5'd7, 32'hDDDD); expect_wr(5'd7, 32'hDDDD); tick();
      mdu(1'b0, 5'd0, 32'd0);
      tick();
      idle_check("waw_push_done");

      // Flush with stall gives a bubble; stall alone re-drives the held write
      stall = 1'b1; flush = 1'b1; pipe(5'd15, 32'h1515, 1'b0); tick();
      chk("flush_stall_regwr", wb_regwr, 1'b0);
      stall = 1'b0; flush = 1'b0;
      pipe(5'd16, 32'h1616, 1'b1); tick();
      stall = 1'b1; pipe(5'd17, 32'h1717, 1'b0); expect_wr(5'd16, 32'h1616); tick();
      stall = 1'b0; bubble(); tick();
      idle_check("stall_released");

      // Pipeline write to reg 0 frees the port for the FIFO
      pipe(5'd9, 32'h300, 1'b1); mdu(1'b1, 5'd3, 32'h3333); tick();
      mdu(1'b0, 5'd0, 32'd0);
      pipe(5'd0, 32'h777, 1'b0); expect_wr(5'd3, 32'h3333); tick();
      chk("reg0_drain_addr", wb_addr, 5'd3);
      bubble(); tick();
      idle_check("reg0_done");

      // MDU push to reg 0 is accepted but never written
      pipe(5'd9, 32'h400, 1'b1); mdu(1'b1, 5'd0, 32'hBAD); tick();
      mdu(1'b0, 5'd0, 32'd0);
      chk("mdu_addr0_pending", wb_pending, 1'b0);
      bubble(); tick();
      idle_check("mdu_addr0_idle");

      // Reset with two pending entries discards them
      pipe(5'd9, 32'h500, 1'b1); mdu(1'b1, 5'd1, 32'h11); tick();
      pipe(5'd9, 32'h501, 1'b1); mdu(1'b1, 5'd2, 32'h22); tick();
      mdu(1'b0, 5'd0, 32'd0);
      chk("pre_reset_pending", wb_pending, 1'b1);
      chk("pre_reset_ready", mdu_ready, 1'b0);
      rst = 1'b1; bubble(); tick();
      idle_check("mid_reset");
      chk("mid_reset_ready", mdu_ready, 1'b0);
      rst = 1'b0; tick();
      idle_check("post_reset");
      chk("post_reset_ready", mdu_ready, 1'b1);

      chk("scoreboard_empty", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/b_wb_stage.md
Name: b_wb_stage

Overview:
- Writeback stage of the MIPS pipeline: MEM/WB pipeline register, load-data extraction and the driver for the register block's single write port.
- Also arbitrates that write port between in-order pipeline results and out-of-order results from the long-latency multiply/divide unit (MDU), using a small pending-write FIFO.
- Outputs connect directly to the register block's write address, write data and regwr inputs. The register block writes on the falling edge, so a value presented in cycle N is committed mid-cycle N.

Parameters:
- DATA_W, 32: datapath width.
- ADDR_W, 5: register address width.
- FIFO_DEPTH, 2: MDU pending-write entries; must be a power of two and at least 2.

Ports:
- i_sys_clock  in  1  system clock; rising edge for all state.
- i_sys_reset  in  1  synchronous, active-high reset.
- i_wb_stall  in  1  hold the WB register.
- i_wb_flush  in  1  insert a bubble into the WB register.
- i_mem_valid  in  1  MEM stage holds a valid instruction.
- i_mem_regwr  in  1  instruction writes a register.
- i_mem_memtoreg  in  1  1 selects load data, 0 selects ALU result.
- i_mem_wr_addr  in  ADDR_W  destination register.
- i_mem_alu_result  in  DATA_W  ALU result / effective address.
- i_mem_load_data  in  DATA_W  raw aligned word from data memory.
- i_mem_load_type  in  3  load_type_e.
- i_mdu_valid  in  1  MDU result offered.
- i_mdu_wr_addr  in  ADDR_W  MDU destination register.
- i_mdu_wr_data  in  DATA_W  MDU result.
- o_mdu_ready  out  1  FIFO accepts the MDU result this cycle.
- o_wb_regwr  out  1  to register block regwr.
- o_wb_wr_addr  out  ADDR_W  to register block write address.
- o_wb_wr_data  out  DATA_W  to register block write data.
- o_wb_pending  out  1  FIFO non-empty, for the hazard unit.

Behaviour:
- Reset (synchronous, active-high):
  - WB valid cleared, FIFO emptied.
  - o_wb_regwr=0, o_wb_wr_addr=0, o_wb_wr_data=0, o_wb_pending=0.
  - o_mdu_ready=0 while reset is asserted.
  - Reset asserted mid-drain discards all FIFO entries.
- WB register, updated each rising edge:
  - Flush has priority over stall: captures valid=0.
  - Else stall: holds its contents.
  - Else captures the MEM inputs.
  - Load extraction is performed before capture, so the register stores the final write data.
- Load extraction (little-endian; byte k = bits [8k+7:8k]; k = alu_result[1:0]; half select = alu_result[1]):
  - LW: word unchanged.
  - LH: sign-extended half.
  - LHU: zero-extended half.
  - LB: sign-extended byte.
  - LBU: zero-extended byte.
  - Misalignment is not checked.
- Pipeline write is active when WB valid && regwr && addr != 0.
- Write port (combinational from state; latency MEM→write port = 1 clock):
  - If a pipeline write is active: drive the pipeline write.
  - Else if the FIFO is non-empty: drive the FIFO head with regwr=1 and pop at the next edge (stall does not block the pop).
  - Else: regwr=0, addr=0, data=0.
  - A pipeline write held under stall is re-driven each cycle; this is idempotent.
- MDU FIFO:
  - o_mdu_ready = !reset && count < FIFO_DEPTH, based on count only; there is no pass-through when full.
  - Push on i_mdu_valid && o_mdu_ready.
  - A push with addr 0 is accepted and discarded.
  - A pushed entry is not poppable in the same cycle.
  - Simultaneous push and pop: count unchanged, order preserved.
  - The MDU holds its result while ready=0.
- WAW squash: when a pipeline write is active, any FIFO entry with the same address is invalidated at that edge. The newer pipeline value wins, and the squashed entry never reaches the port.
  - A push arriving the same cycle with a matching address is NOT squashed; it is treated as newer.
- o_wb_pending = FIFO holds at least one valid entry.

Decomposition:
- Shared package b_pkg:
  - load_type_e: LT_LW=0, LT_LH=1, LT_LHU=2, LT_LB=3, LT_LBU=4.
  - DATA_W and ADDR_W constants.
- Sub-module b_wb_fifo: FIFO_DEPTH-entry queue with per-entry valid bits and a squash-by-address input.
  - Invalid heads are skipped when popped without using the port.

Test Plan:
- Reset, then LW to reg 8 with load_data 0x8899AABB -> next cycle o_wb_regwr=1, addr 8, data 0x8899AABB; during reset all outputs are 0 and o_mdu_ready=0.
- load_data 0x80112233:
  - LB, addr[1:0]=3 -> 0xFFFFFF80.
  - LBU -> 0x00000080.
  - LH, addr[1]=1 -> 0xFFFF8011.
  - LHU -> 0x00008011.
- MDU push reg 5 = 0x1234 while the pipeline writes reg 9 each cycle -> o_wb_pending=1 and port shows reg 9; first bubble -> port shows reg 5 = 0x1234, then pending drops to 0.
- Push two entries with no drain -> o_mdu_ready=0 and the third is held; one drain -> ready=1 the following cycle and the held entry is accepted.
- FIFO holds reg 7 = 0xAAAA, pipeline writes reg 7 = 0xBBBB -> only 0xBBBB ever appears on the port for reg 7.
- Flush and stall together -> bubble with regwr=0. A pipeline write to reg 0 -> regwr=0 and the FIFO drains that cycle. Reset asserted with 2 pending entries -> FIFO empty, pending=0 next cycle.
